// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32 decode pipeline.
// Latency: n/a (package). Backpressure: n/a.
// Contents: opcode constants, wb/mem/alu encodings, ctrl_t bundle, alu_op helper.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b011;
  localparam logic [2:0] MEM_LHU = 3'b100;
  localparam logic [2:0] MEM_SB  = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SW  = 3'b111;

  // alu_op is carried at its widest (M enabled) and narrowed at the top.
  localparam int         ALU_OP_MAX_W = 5;
  localparam logic [4:0] ALU_ADD      = 5'b00000;
  localparam logic [4:0] ALU_M_BASE   = 5'b10000;

  // PC is carried at a fixed maximum width so the struct is parameter-free.
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic                    reg_wr;
    logic                    mem_rd;
    logic                    mem_wr;
    logic                    alu_s1;
    logic                    alu_s2;
    logic                    do_branch;
    logic                    jump_ctrl;
    logic [1:0]              wb_ctrl;
    logic [ALU_OP_MAX_W-1:0] alu_op;
    logic [2:0]              branch_ctrl;
    logic [2:0]              mem_ctrl;
    logic [4:0]              rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [PC_MAX_W-1:0]     pc;
    logic                    illegal;
  } ctrl_t;

  // Register-register base op: f7[5] selects SUB/SRA only for ADD/SR funct3.
  function automatic logic [4:0] base_alu_op(input logic [2:0] f3, input logic [6:0] f7);
    return {1'b0, f7[5] & ((f3 == 3'b000) || (f3 == 3'b101)), f3};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32 instruction -> ctrl_t mapping (pc field left 0).
// Latency: 0 cycles. Backpressure: none, pure function of instr.
// Ports: instr (32-bit word in), ctrl (decoded bundle out).
module decode_comb
  import decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;
  ctrl_t      c;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    c     = '0;
    bad   = 1'b0;
    c.rd  = instr[11:7];
    c.rs1 = instr[19:15];
    c.rs2 = instr[24:20];
    case (opcode)
      OP_R: begin
        c.reg_wr  = 1'b1;
        c.wb_ctrl = WB_ALU;
        c.alu_s1  = 1'b1;
        c.alu_s2  = 1'b1;
        if (ENABLE_M && (f7 == 7'b0000001)) c.alu_op = ALU_M_BASE | {2'b00, f3};
        else                                c.alu_op = base_alu_op(f3, f7);
        bad = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                (ENABLE_M && (f7 == 7'b0000001)));
      end
      OP_I: begin
        c.reg_wr  = 1'b1;
        c.wb_ctrl = WB_ALU;
        c.alu_s1  = 1'b1;
        // Only SRAI uses f7; for every other funct3 those bits are immediate.
        c.alu_op  = {2'b00, (f3 == 3'b101) && (f7 == 7'b0100000), f3};
        if (f3 == 3'b001)      bad = (f7 != 7'b0000000);
        else if (f3 == 3'b101) bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
      end
      OP_LOAD: begin
        c.reg_wr  = 1'b1;
        c.mem_rd  = 1'b1;
        c.wb_ctrl = WB_MEM;
        c.alu_s1  = 1'b1;
        c.alu_op  = ALU_ADD;
        case (f3)
          3'b000:  c.mem_ctrl = MEM_LB;
          3'b001:  c.mem_ctrl = MEM_LH;
          3'b010:  c.mem_ctrl = MEM_LW;
          3'b100:  c.mem_ctrl = MEM_LBU;
          3'b101:  c.mem_ctrl = MEM_LHU;
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        c.mem_wr  = 1'b1;
        c.wb_ctrl = WB_MEM;
        c.alu_s1  = 1'b1;
        c.alu_op  = ALU_ADD;
        case (f3)
          3'b000:  c.mem_ctrl = MEM_SB;
          3'b001:  c.mem_ctrl = MEM_SH;
          3'b010:  c.mem_ctrl = MEM_SW;
          default: bad = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        c.do_branch   = 1'b1;
        c.branch_ctrl = f3;
        bad           = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LUI: begin
        c.reg_wr  = 1'b1;
        c.wb_ctrl = WB_ALU;
        c.alu_s1  = 1'b1;
      end
      OP_AUIPC: begin
        c.reg_wr  = 1'b1;
        c.wb_ctrl = WB_ALU;
      end
      OP_JAL: begin
        c.reg_wr    = 1'b1;
        c.wb_ctrl   = WB_PC4;
        c.jump_ctrl = 1'b1;
      end
      OP_JALR: begin
        c.reg_wr    = 1'b1;
        c.wb_ctrl   = WB_PC4;
        c.alu_s1    = 1'b1;
        c.jump_ctrl = 1'b1;
        bad         = (f3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    // Illegal words must not cause any architectural side effect downstream.
    if (bad) begin
      c.reg_wr    = 1'b0;
      c.mem_rd    = 1'b0;
      c.mem_wr    = 1'b0;
      c.do_branch = 1'b0;
      c.jump_ctrl = 1'b0;
    end
    c.illegal = bad;
  end

  assign ctrl = c;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32 decoder with a 2-entry skid buffer between fetch and execute.
// Latency: 1 cycle from accept to out_valid when empty. Backpressure: in_ready = count<2, registered.
// Ports: clk/rst, instr_i/pc_i/in_valid/in_ready, flush, out_valid/out_ready, decoded control + pc_o.
module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter bit  ENABLE_M = 1'b0,
  localparam int ALU_OP_W = ENABLE_M ? 5 : 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                reg_wr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                alu_s1,
  output logic                alu_s2,
  output logic                do_branch,
  output logic                jump_ctrl,
  output logic [1:0]          wb_ctrl,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          branch_ctrl,
  output logic [2:0]          mem_ctrl,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [XLEN-1:0]     pc_o,
  output logic                illegal
);

  ctrl_t      dec, dec_pc, ent0, ent1, head;
  logic [1:0] count, count_nx;
  logic       in_ready_q, push, pop;
  logic       unused_bits;

  decode_comb #(.ENABLE_M(ENABLE_M)) u_decode_comb (
    .instr (instr_i),
    .ctrl  (dec)
  );

  always_comb begin
    dec_pc    = dec;
    dec_pc.pc = PC_MAX_W'(pc_i);
  end

  assign push      = in_valid && in_ready_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_nx = count;
    if (flush) count_nx = 2'd0;
    else begin
      case (count)
        2'd0:    if (push) count_nx = 2'd1;
        2'd1:    if (push && !pop) count_nx = 2'd2;
                 else if (!push && pop) count_nx = 2'd0;
        2'd2:    if (pop) count_nx = 2'd1;
        default: count_nx = 2'd0;
      endcase
    end
  end

  // ent0 is always the head; ent1 only holds the second entry in TWO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      in_ready_q <= 1'b1;
      ent0       <= '0;
      ent1       <= '0;
    end else begin
      count      <= count_nx;
      in_ready_q <= (count_nx != 2'd2);
      if (flush) begin
        ent0 <= '0;
        ent1 <= '0;
      end else begin
        case (count)
          2'd0: if (push) ent0 <= dec_pc;
          2'd1: if (push && pop) ent0 <= dec_pc;
                else if (push) ent1 <= dec_pc;
          2'd2: if (pop) ent0 <= ent1;
          default: ;
        endcase
      end
    end
  end

  // Stale head contents are masked so an empty buffer shows all-zero fields.
  assign head = out_valid ? ent0 : '0;

  assign in_ready    = in_ready_q;
  assign reg_wr      = head.reg_wr;
  assign mem_rd      = head.mem_rd;
  assign mem_wr      = head.mem_wr;
  assign alu_s1      = head.alu_s1;
  assign alu_s2      = head.alu_s2;
  assign do_branch   = head.do_branch;
  assign jump_ctrl   = head.jump_ctrl;
  assign wb_ctrl     = head.wb_ctrl;
  assign alu_op      = head.alu_op[ALU_OP_W-1:0];
  assign branch_ctrl = head.branch_ctrl;
  assign mem_ctrl    = head.mem_ctrl;
  assign rd          = head.rd;
  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign pc_o        = head.pc[XLEN-1:0];
  assign illegal     = head.illegal;

  assign unused_bits = ^{head.alu_op, head.pc};

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

  typedef struct packed {
    logic        reg_wr, mem_rd, mem_wr, alu_s1, alu_s2, do_branch, jump_ctrl;
    logic [1:0]  wb_ctrl;
    logic [4:0]  alu_op;
    logic [2:0]  branch_ctrl, mem_ctrl;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc;
    logic        illegal;
  } obs_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h00812283;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JALR = 32'h000280E7;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic        a0_reg_wr, a0_mem_rd, a0_mem_wr, a0_alu_s1, a0_alu_s2, a0_do_branch, a0_jump_ctrl, a0_illegal;
  logic        a1_reg_wr, a1_mem_rd, a1_mem_wr, a1_alu_s1, a1_alu_s2, a1_do_branch, a1_jump_ctrl, a1_illegal;
  logic [1:0]  a0_wb_ctrl, a1_wb_ctrl;
  logic [3:0]  a0_alu_op;
  logic [4:0]  a1_alu_op;
  logic [2:0]  a0_branch_ctrl, a0_mem_ctrl, a1_branch_ctrl, a1_mem_ctrl;
  logic [4:0]  a0_rd, a0_rs1, a0_rs2, a1_rd, a1_rs1, a1_rs2;
  logic [31:0] a0_pc, a1_pc;
  obs_t        obs0, obs1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .instr_i(instr_i), .pc_i(pc_i), .in_valid(in_valid),
    .in_ready(in_ready0), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .reg_wr(a0_reg_wr), .mem_rd(a0_mem_rd), .mem_wr(a0_mem_wr), .alu_s1(a0_alu_s1),
    .alu_s2(a0_alu_s2), .do_branch(a0_do_branch), .jump_ctrl(a0_jump_ctrl),
    .wb_ctrl(a0_wb_ctrl), .alu_op(a0_alu_op), .branch_ctrl(a0_branch_ctrl),
    .mem_ctrl(a0_mem_ctrl), .rd(a0_rd), .rs1(a0_rs1), .rs2(a0_rs2), .pc_o(a0_pc),
    .illegal(a0_illegal)
  );

  decode_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .instr_i(instr_i), .pc_i(pc_i), .in_valid(in_valid),
    .in_ready(in_ready1), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .reg_wr(a1_reg_wr), .mem_rd(a1_mem_rd), .mem_wr(a1_mem_wr), .alu_s1(a1_alu_s1),
    .alu_s2(a1_alu_s2), .do_branch(a1_do_branch), .jump_ctrl(a1_jump_ctrl),
    .wb_ctrl(a1_wb_ctrl), .alu_op(a1_alu_op), .branch_ctrl(a1_branch_ctrl),
    .mem_ctrl(a1_mem_ctrl), .rd(a1_rd), .rs1(a1_rs1), .rs2(a1_rs2), .pc_o(a1_pc),
    .illegal(a1_illegal)
  );

  assign obs0 = {a0_reg_wr, a0_mem_rd, a0_mem_wr, a0_alu_s1, a0_alu_s2, a0_do_branch, a0_jump_ctrl,
                 a0_wb_ctrl, {1'b0, a0_alu_op}, a0_branch_ctrl, a0_mem_ctrl, a0_rd, a0_rs1, a0_rs2,
                 a0_pc, a0_illegal};
  assign obs1 = {a1_reg_wr, a1_mem_rd, a1_mem_wr, a1_alu_s1, a1_alu_s2, a1_do_branch, a1_jump_ctrl,
                 a1_wb_ctrl, a1_alu_op, a1_branch_ctrl, a1_mem_ctrl, a1_rd, a1_rs1, a1_rs2,
                 a1_pc, a1_illegal};

  // Reference decode written from the instruction-set rules, one opcode per arm.
  function automatic obs_t model(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
    obs_t       o;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    o  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1;
    o.rd = ins[11:7]; o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.pc = pc;
    case (ins[6:0])
      7'h33: begin
        {o.reg_wr, o.wb_ctrl, o.alu_s1, o.alu_s2} = {1'b1, 2'b01, 1'b1, 1'b1};
        if (en_m && f7 == 7'd1) o.alu_op = 5'd16 + 5'(f3);
        else o.alu_op = 5'(f3) + ((f7[5] && (f3 == 0 || f3 == 5)) ? 5'd8 : 5'd0);
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (en_m && f7 == 1);
      end
      7'h13: begin
        {o.reg_wr, o.wb_ctrl, o.alu_s1} = {1'b1, 2'b01, 1'b1};
        o.alu_op = 5'(f3) + ((f3 == 5 && f7 == 7'h20) ? 5'd8 : 5'd0);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
      end
      7'h03: begin
        {o.reg_wr, o.mem_rd, o.alu_s1} = 3'b111;
        case (f3)
          0, 1, 2: o.mem_ctrl = f3;
          4, 5:    o.mem_ctrl = f3 - 3'd1;
          default: ok = 0;
        endcase
      end
      7'h23: begin
        {o.mem_wr, o.alu_s1} = 2'b11;
        if (f3 <= 2) o.mem_ctrl = f3 + 3'd5; else ok = 0;
      end
      7'h63: begin
        o.do_branch = 1; o.branch_ctrl = f3;
        ok = !(f3 == 2 || f3 == 3);
      end
      7'h37: {o.reg_wr, o.wb_ctrl, o.alu_s1} = {1'b1, 2'b01, 1'b1};
      7'h17: {o.reg_wr, o.wb_ctrl} = {1'b1, 2'b01};
      7'h6F: {o.reg_wr, o.wb_ctrl, o.jump_ctrl} = {1'b1, 2'b10, 1'b1};
      7'h67: begin
        {o.reg_wr, o.wb_ctrl, o.alu_s1, o.jump_ctrl} = {1'b1, 2'b10, 1'b1, 1'b1};
        ok = (f3 == 0);
      end
      default: ok = 0;
    endcase
    if (!ok) {o.reg_wr, o.mem_rd, o.mem_wr, o.do_branch, o.jump_ctrl} = '0;
    o.illegal = !ok;
    return o;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid = iv; instr_i = ins; pc_i = pc; out_ready = ordy; flush = fl;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b/%b exp 0", out_valid0, out_valid1); end
    n_checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b/%b exp 1", in_ready0, in_ready1); end
    n_checks++; if (obs0 !== '0 || obs1 !== '0) begin n_fail++; $display("FAIL reset_outputs got %h / %h exp 0", obs0, obs1); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive(1, I_ADD, 32'h100, 1, 0);
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL add_latency out_valid got %b/%b exp 1", out_valid0, out_valid1); end
    n_checks++; if ({a0_alu_op, a0_reg_wr, a0_wb_ctrl, a0_rd, a0_rs1, a0_rs2, a0_illegal} !== {4'b0000, 1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0})
      begin n_fail++; $display("FAIL add_fields got op=%b wr=%b wb=%b rd=%0d rs1=%0d rs2=%0d ill=%b", a0_alu_op, a0_reg_wr, a0_wb_ctrl, a0_rd, a0_rs1, a0_rs2, a0_illegal); end
    n_checks++; if (obs1 !== model(I_ADD, 32'h100, 1)) begin n_fail++; $display("FAIL add_model_m got %h exp %h", obs1, model(I_ADD, 32'h100, 1)); end
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL add_drain out_valid got %b exp 0", out_valid0); end
  endtask

  task automatic test_back_to_back();
    drive(1, I_SUB, 32'h200, 1, 0);
    @(negedge clk);
    n_checks++; if (a0_alu_op !== 4'b1000 || a1_alu_op !== 5'b01000 || out_valid0 !== 1'b1) begin n_fail++; $display("FAIL b2b_sub alu_op got %b/%b exp 1000", a0_alu_op, a1_alu_op); end
    drive(1, I_LW, 32'h204, 1, 0);
    @(negedge clk);
    n_checks++; if ({out_valid0, a0_mem_rd, a0_mem_ctrl, a0_wb_ctrl, a0_rd} !== {1'b1, 1'b1, 3'b010, 2'b00, 5'd5})
      begin n_fail++; $display("FAIL b2b_lw got v=%b rd_en=%b mc=%b wb=%b rd=%0d", out_valid0, a0_mem_rd, a0_mem_ctrl, a0_wb_ctrl, a0_rd); end
    n_checks++; if (obs0 !== model(I_LW, 32'h204, 0)) begin n_fail++; $display("FAIL b2b_lw_model got %h exp %h", obs0, model(I_LW, 32'h204, 0)); end
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    drive(1, I_ADD, 32'h300, 0, 0);
    @(negedge clk);
    n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL bp_one in_ready got %b exp 1", in_ready0); end
    drive(1, I_SUB, 32'h304, 0, 0);
    @(negedge clk);
    drive(1, I_LW, 32'h308, 0, 0);
    n_checks++; if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin n_fail++; $display("FAIL bp_full in_ready got %b/%b exp 0", in_ready0, in_ready1); end
    @(negedge clk);
    n_checks++; if (obs0 !== model(I_ADD, 32'h300, 0) || in_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_hold head got %h exp %h", obs0, model(I_ADD, 32'h300, 0)); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (obs0 !== model(I_SUB, 32'h304, 0) || in_ready0 !== 1'b1) begin n_fail++; $display("FAIL bp_second head got %h exp %h", obs0, model(I_SUB, 32'h304, 0)); end
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    n_checks++; if (obs0 !== model(I_LW, 32'h308, 0) || out_valid0 !== 1'b1) begin n_fail++; $display("FAIL bp_third head got %h exp %h", obs0, model(I_LW, 32'h308, 0)); end
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup out_valid got %b exp 0", out_valid0); end
  endtask

  task automatic test_branch_jalr();
    drive(1, I_BEQ, 32'h400, 1, 0);
    @(negedge clk);
    n_checks++; if ({a0_do_branch, a0_branch_ctrl, a0_mem_wr} !== {1'b1, 3'b000, 1'b0}) begin n_fail++; $display("FAIL beq got br=%b bc=%b mw=%b", a0_do_branch, a0_branch_ctrl, a0_mem_wr); end
    drive(1, I_JALR, 32'h404, 1, 0);
    @(negedge clk);
    n_checks++; if ({a0_jump_ctrl, a0_wb_ctrl, a0_alu_s1} !== {1'b1, 2'b10, 1'b1}) begin n_fail++; $display("FAIL jalr got j=%b wb=%b s1=%b", a0_jump_ctrl, a0_wb_ctrl, a0_alu_s1); end
    n_checks++; if (obs1 !== model(I_JALR, 32'h404, 1)) begin n_fail++; $display("FAIL jalr_model got %h exp %h", obs1, model(I_JALR, 32'h404, 1)); end
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
  endtask

  task automatic test_m_ext();
    drive(1, I_MUL, 32'h500, 1, 0);
    @(negedge clk);
    n_checks++; if (a0_illegal !== 1'b1 || a0_reg_wr !== 1'b0) begin n_fail++; $display("FAIL mul_no_m got ill=%b wr=%b exp 1/0", a0_illegal, a0_reg_wr); end
    n_checks++; if (a1_alu_op !== 5'b10000 || a1_illegal !== 1'b0) begin n_fail++; $display("FAIL mul_m got op=%b ill=%b exp 10000/0", a1_alu_op, a1_illegal); end
    drive(1, I_BAD, 32'h504, 1, 0);
    @(negedge clk);
    n_checks++; if (a0_illegal !== 1'b1 || a1_illegal !== 1'b1 || a1_reg_wr !== 1'b0) begin n_fail++; $display("FAIL bad_opcode got ill=%b/%b wr=%b", a0_illegal, a1_illegal, a1_reg_wr); end
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
  endtask

  task automatic test_flush();
    drive(1, I_ADD, 32'h600, 0, 0);
    @(negedge clk);
    drive(1, I_SUB, 32'h604, 0, 0);
    @(negedge clk);
    drive(1, I_LW, 32'h608, 1, 1);
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_two got v=%b r=%b exp 0/1", out_valid0, in_ready0); end
    drive(1, I_ADD, 32'h60C, 0, 0);
    @(negedge clk);
    drive(1, I_BEQ, 32'h610, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    n_checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin n_fail++; $display("FAIL flush_drop got v=%b r=%b exp 0/1", out_valid0, in_ready0); end
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_never_appears got v=%b/%b exp 0", out_valid0, out_valid1); end
  endtask

  task automatic test_async_reset();
    drive(1, I_ADD, 32'h700, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || obs0 !== '0 || obs1 !== '0) begin n_fail++; $display("FAIL async_reset got v=%b r=%b o=%h", out_valid0, in_ready0, obs0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL post_reset out_valid got %b exp 0", out_valid0); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;  7: w[6:0] = 7'h6F;  8: w[6:0] = 7'h67;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;  2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_random();
    logic [63:0] q[$];
    logic        iv, ordy, fl, do_push, do_pop;
    logic [31:0] ins, pc;
    q = {};
    for (int cyc = 0; cyc < 500; cyc++) begin
      n_checks++; if (out_valid0 !== (q.size() != 0) || out_valid1 !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d got %b/%b exp %0d", cyc, out_valid0, out_valid1, q.size() != 0); end
      n_checks++; if (in_ready0 !== (q.size() < 2) || in_ready1 !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b/%b exp %0d", cyc, in_ready0, in_ready1, q.size() < 2); end
      if (q.size() != 0) begin
        n_checks++; if (obs0 !== model(q[0][63:32], q[0][31:0], 0)) begin n_fail++; $display("FAIL rnd_head_nom cyc %0d got %h exp %h", cyc, obs0, model(q[0][63:32], q[0][31:0], 0)); end
        n_checks++; if (obs1 !== model(q[0][63:32], q[0][31:0], 1)) begin n_fail++; $display("FAIL rnd_head_m cyc %0d got %h exp %h", cyc, obs1, model(q[0][63:32], q[0][31:0], 1)); end
      end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      ins  = rand_instr();
      pc   = $urandom & 32'hFFFF_FFFC;
      drive(iv, ins, pc, ordy, fl);
      do_push = iv && (q.size() < 2);
      do_pop  = ordy && (q.size() != 0);
      if (fl) q = {};
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back({ins, pc});
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_branch_jalr();
    test_m_ext();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Registered, parametrised RV32 instruction decoder that sits between fetch and execute.
- Accepts a 32-bit instruction plus PC over a valid/ready handshake.
- Decodes the full control bundle, register indices and an illegal-instruction flag.
- Presents the result through a 2-entry skid buffer so downstream back-pressure never creates a combinational ready path to fetch.
- Adds optional M-extension decoding, flush, and fully defined (no-X) outputs.

Parameters:
- XLEN, 32, width of the PC carried alongside the instruction.
- ENABLE_M, 0, 1 = decode MUL/DIV/REM (opcode 0110011, f7 0000001); 0 = flag them illegal.
- ALU_OP_W, 4 if ENABLE_M=0 else 5 (derived, not user-set), width of alu_op.

Ports:
- clk in 1 system clock
- rst in 1 asynchronous active-high reset
- instr_i in 32 instruction word
- pc_i in XLEN PC of instr_i
- in_valid in 1 instr_i/pc_i valid
- in_ready out 1 block can accept this cycle
- flush in 1 discard all buffered entries
- out_valid out 1 head entry valid
- out_ready in 1 execute consumes head entry
- reg_wr, mem_rd, mem_wr, alu_s1, alu_s2, do_branch, jump_ctrl out 1 each, control bits
- wb_ctrl out 2, 00 mem, 01 alu, 10 pc+4
- alu_op out ALU_OP_W, ALU operation
- branch_ctrl out 3, branch f3
- mem_ctrl out 3, 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- rd, rs1, rs2 out 5 each, register indices
- pc_o out XLEN, PC of head entry
- illegal out 1, head entry is an undecodable instruction

Behaviour:
- Reset (async, rst=1): buffer count=0, out_valid=0, in_ready=1. All data outputs are 0. Deassertion is used synchronously.
- Input handshake: accept when in_valid && in_ready. in_ready = (count<2), registered and derived from state only, never from out_ready.
- Output handshake: pop when out_valid && out_ready. The head stays stable while out_valid && !out_ready.
- Latency: an instruction accepted in cycle N appears at the outputs in cycle N+1 if the buffer was empty.
- Buffer states:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push+pop -> ONE, new entry becomes head.
  - TWO: pop -> ONE, second entry becomes head. No push is possible because in_ready=0.
- flush: takes priority over push and pop in the same cycle. Result is count=0 and out_valid=0. An input presented in the flush cycle is dropped.
- No X outputs: every field not meaningful for an opcode drives 0.
- Decode table, fields {reg_wr, mem_rd, mem_wr, wb_ctrl, alu_s1, alu_s2, do_branch, jump_ctrl}:
  - 0110011 R: 1,0,0,01,1,1,0,0
  - 0010011 I: 1,0,0,01,1,0,0,0
  - 0000011 load: 1,1,0,00,1,0,0,0, alu_op ADD
  - 0100011 store: 0,0,1,00,1,0,0,0, alu_op ADD
  - 1100011 branch: 0,0,0,00,0,0,1,0, branch_ctrl=f3. mem_wr must be 0.
  - 0110111 LUI: 1,0,0,01,1,0,0,0
  - 0010111 AUIPC: 1,0,0,01,0,0,0,0
  - 1101111 JAL: 1,0,0,10,0,0,0,1
  - 1100111 JALR: 1,0,0,10,1,0,0,1
- alu_op encoding:
  - Base ops are {0, f7[5]&(f3==000 or 101), f3}. SUB/SRA set bit 3.
  - For I-type, bit 3 is set only for f3=101 with f7=0100000. ADDI ignores f7.
  - With ENABLE_M, M ops are {1,0,f3}.
- illegal=1 for any of:
  - unknown opcode
  - R-type f7 not in {0000000, 0100000 (f3 000/101 only), 0000001 with ENABLE_M}
  - load f3 in {011, 110, 111}
  - store f3 > 010
  - branch f3 in {010, 011}
  - JALR f3 != 000
  - shift-immediate with bad f7
- When illegal=1: reg_wr, mem_rd, mem_wr, do_branch and jump_ctrl are forced to 0. rd/rs1/rs2 are still extracted.
- Reset mid-operation: buffer contents are lost and count returns to 0 immediately.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR)
  - wb_ctrl, mem_ctrl and alu_op localparams
  - a packed struct ctrl_t holding every control output plus rd/rs1/rs2/pc/illegal
- One sub-module, decode_comb: a purely combinational instr -> ctrl_t mapping, parametrised by ENABLE_M.
- decode_ctrl_pipe holds the skid buffer of ctrl_t.

Test Plan:
- Reset, then 0x002081B3 (add x3,x1,x2) with out_ready=1 -> next cycle:
  - out_valid=1, alu_op=0000, reg_wr=1, wb_ctrl=01, rd=3, rs1=1, rs2=2, illegal=0.
- 0x402081B3 (sub) then 0x00812283 (lw x5,8(x2)), back-to-back ->
  - first output: alu_op=1000.
  - second output: mem_rd=1, mem_ctrl=010, wb_ctrl=00, rd=5.
- out_ready=0 while pushing 3 instructions ->
  - in_ready drops to 0 after 2 accepts and the third is held upstream.
  - Release out_ready -> all 3 emerge in order, no loss or duplication.
- 0x00208463 (beq) -> do_branch=1, branch_ctrl=000, mem_wr=0. Then 0x000280E7 (jalr x1,0(x5)) -> jump_ctrl=1, wb_ctrl=10, alu_s1=1.
- 0x022081B3 (mul) ->
  - ENABLE_M=0: illegal=1, reg_wr=0.
  - ENABLE_M=1: alu_op=10000, illegal=0.
  - Opcode 0x7F word -> illegal=1.
- Buffer in TWO state, assert flush together with in_valid ->
  - next cycle out_valid=0, in_ready=1.
  - The dropped instruction never appears.
  - Assert rst mid-stream -> outputs are 0 asynchronously.
